// File: rtl/cla4_bist_checker_pkg.sv
// Shared types and widths for the 4-bit CLA built-in self-test checker.
package cla4_bist_pkg;

    localparam int OPW  = 4;
    localparam int VECW = 8;
    localparam int SUMW = 5;
    localparam int CNTW = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cla4_bist_checker_if.sv
// Operand/sum bus between the checker and the adder under test.
interface cla4_bist_checker_if;
    import cla4_bist_pkg::*;

    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [OPW-1:0] s;
    logic           cout;

    modport master (output a, output b, input s, input cout);
    modport slave  (input a, input b, output s, output cout);

endinterface

// File: rtl/cla4_bist_checker_golden.sv
// Reference sum for the adder under test; swap this module to retarget other widths.
module cla4_golden
    import cla4_bist_pkg::*;
(
    input  logic [OPW-1:0]  i_a,
    input  logic [OPW-1:0]  i_b,
    output logic [SUMW-1:0] o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/cla4_bist_checker.sv
// Exhaustive 256-vector stimulus/response checker for the 4-bit carry-lookahead adder.
// state  | meaning
// IDLE   | after reset, waiting for start
// DRIVE  | register a/b from vector index v
// SETTLE | wait SETTLE cycles for the adder to settle
// CHECK  | compare {cout,s} with golden sum, advance v
// DONE   | results valid, waiting for start to rerun
module cla4_bist_checker
    import cla4_bist_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    cla4_bist_checker_if.master adder,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [CNTW-1:0]     o_err_count,
    output logic                o_fail_valid,
    output logic [VECW-1:0]     o_first_fail
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCW-1:0] SETTLE_LD = SCW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [VECW-1:0]  r_v;
    logic [SCW-1:0]   r_settle_cnt;
    logic [OPW-1:0]   r_a;
    logic [OPW-1:0]   r_b;
    logic [CNTW-1:0]  r_err_count;
    logic             r_fail_valid;
    logic [VECW-1:0]  r_first_fail;
    logic [SUMW-1:0]  w_expected;
    logic             w_mismatch;

    cla4_golden u_golden (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_expected)
    );

    assign w_mismatch = (w_expected != {adder.cout, adder.s});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (i_start) w_next = ST_DRIVE;
            ST_DRIVE:         w_next = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE:        if (r_settle_cnt == '0) w_next = ST_CHECK;
            ST_CHECK:         w_next = (r_v == '1) ? ST_DONE : ST_DRIVE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Results are cleared on run acceptance so a restart from DONE never mixes runs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v          <= '0;
            r_settle_cnt <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_v          <= '0;
                        r_err_count  <= '0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= '0;
                    end
                end
                ST_DRIVE: begin
                    r_a          <= r_v[VECW-1:OPW];
                    r_b          <= r_v[OPW-1:0];
                    r_settle_cnt <= SETTLE_LD;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + 1'b1;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_first_fail <= {r_a, r_b};
                        end
                    end
                    if (r_v != '1) r_v <= r_v + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign adder.a      = r_a;
    assign adder.b      = r_b;
    assign o_busy       = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign o_done       = (r_state == ST_DONE);
    assign o_pass       = o_done && (r_err_count == '0);
    assign o_err_count  = r_err_count;
    assign o_fail_valid = r_fail_valid;
    assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_cla4_bist_checker.sv
// Self-checking bench: two checker instances (SETTLE=2 and SETTLE=0) against faultable adder models.
module tb_cla4_bist_checker;
    import cla4_bist_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   sel = 0;
    int   fault1 = 0;
    int   fault2 = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    cla4_bist_checker_if bus1 ();
    cla4_bist_checker_if bus2 ();

    logic             busy1, done1, pass1, fv1, busy2, done2, pass2, fv2;
    logic [CNTW-1:0]  err1, err2;
    logic [VECW-1:0]  ff1, ff2;
    logic             start1, start2;

    assign start1 = start && (sel == 0);
    assign start2 = start && (sel == 1);

    // Faultable adder: 1 = s0 stuck-at-0, 2 = cout stuck-at-0, 3 = wrong sum only at {a,b}=0xA5.
    function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b, input int f);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b};
        case (f)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: if ({a, b} == 8'hA5) r[0] = ~r[0];
            default: ;
        endcase
        return r;
    endfunction

    assign {bus1.cout, bus1.s} = adder_model(bus1.a, bus1.b, fault1);
    assign {bus2.cout, bus2.s} = adder_model(bus2.a, bus2.b, fault2);

    cla4_bist_checker #(.SETTLE(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .adder(bus1.master),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_fail_valid(fv1), .o_first_fail(ff1)
    );

    cla4_bist_checker #(.SETTLE(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .adder(bus2.master),
        .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_count(err2),
        .o_fail_valid(fv2), .o_first_fail(ff2)
    );

    logic            m_busy, m_done, m_pass, m_fv;
    logic [CNTW-1:0] m_err;
    logic [VECW-1:0] m_ff;
    logic [3:0]      m_a, m_b;

    always_comb begin
        m_busy = (sel == 1) ? busy2 : busy1;
        m_done = (sel == 1) ? done2 : done1;
        m_pass = (sel == 1) ? pass2 : pass1;
        m_fv   = (sel == 1) ? fv2   : fv1;
        m_err  = (sel == 1) ? err2  : err1;
        m_ff   = (sel == 1) ? ff2   : ff1;
        m_a    = (sel == 1) ? bus2.a : bus1.a;
        m_b    = (sel == 1) ? bus2.b : bus1.b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_and_measure(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", {31'd0, m_busy}, 32'd1);
        start = 1'b0;
        cyc = 0;
        while (m_busy && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string      name;
        int         sel;
        int         fault;
        int         exp_cyc;
        bit         exp_pass;
        int         exp_err;
        bit         exp_fv;
        logic [7:0] exp_ff;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int cyc;

        tbl[0] = '{"s2_ideal",     0, 0, 1024, 1'b1,   0, 1'b0, 8'h00};
        tbl[1] = '{"s2_s0_stuck",  0, 1, 1024, 1'b0, 128, 1'b1, 8'h01};
        tbl[2] = '{"s2_cout_stuck",0, 2, 1024, 1'b0, 120, 1'b1, 8'h1F};
        tbl[3] = '{"s0_ideal",     1, 0,  512, 1'b1,   0, 1'b0, 8'h00};
        tbl[4] = '{"s0_a5_wrong",  1, 3,  512, 1'b0,   1, 1'b1, 8'hA5};

        #3;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_err",  {23'd0, err1}, 32'd0);
        chk("rst_fv",   {31'd0, fv1}, 32'd0);
        chk("rst_ff",   {24'd0, ff1}, 32'd0);
        chk("rst_ab",   {24'd0, bus1.a, bus1.b}, 32'd0);
        chk("rst_state",{29'd0, dut1.r_state}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            sel = tbl[i].sel;
            if (tbl[i].sel == 1) fault2 = tbl[i].fault;
            else                 fault1 = tbl[i].fault;
            pulse_and_measure(cyc);
            chk({tbl[i].name, "_busy_cycles"}, cyc, tbl[i].exp_cyc);
            chk({tbl[i].name, "_done"}, {31'd0, m_done}, 32'd1);
            chk({tbl[i].name, "_pass"}, {31'd0, m_pass}, {31'd0, tbl[i].exp_pass});
            chk({tbl[i].name, "_err"},  {23'd0, m_err}, tbl[i].exp_err);
            chk({tbl[i].name, "_fv"},   {31'd0, m_fv}, {31'd0, tbl[i].exp_fv});
            chk({tbl[i].name, "_ff"},   {24'd0, m_ff}, {24'd0, tbl[i].exp_ff});
            chk({tbl[i].name, "_ab_hold"}, {24'd0, m_a, m_b}, 32'hFF);
        end

        // Asynchronous reset in the middle of a run.
        sel = 0;
        fault1 = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        chk("midrun_busy", {31'd0, busy1}, 32'd1);
        chk("midrun_err_nonzero", {31'd0, (err1 != 0)}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy1}, 32'd0);
        chk("arst_done", {31'd0, done1}, 32'd0);
        chk("arst_pass", {31'd0, pass1}, 32'd0);
        chk("arst_err",  {23'd0, err1}, 32'd0);
        chk("arst_fv",   {31'd0, fv1}, 32'd0);
        chk("arst_ff",   {24'd0, ff1}, 32'd0);
        chk("arst_ab",   {24'd0, bus1.a, bus1.b}, 32'd0);
        chk("arst_state",{29'd0, dut1.r_state}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        pulse_and_measure(cyc);
        chk("post_rst_cycles", cyc, 1024);
        chk("post_rst_err", {23'd0, err1}, 128);
        chk("post_rst_ff",  {24'd0, ff1}, 32'h01);

        // start held high: no effect while busy, immediate restart from DONE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("held_busy_start", {31'd0, busy1}, 32'd1);
        cyc = 0;
        while (busy1 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk("held_cycles", cyc, 1024);
        chk("held_done", {31'd0, done1}, 32'd1);
        chk("held_err_done", {23'd0, err1}, 128);
        @(negedge clk);
        chk("restart_busy", {31'd0, busy1}, 32'd1);
        chk("restart_done", {31'd0, done1}, 32'd0);
        chk("restart_err_clr", {23'd0, err1}, 0);
        chk("restart_fv_clr", {31'd0, fv1}, 0);
        repeat (4) @(negedge clk);
        chk("restart_err_after_v0", {23'd0, err1}, 0);
        start = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk("restart_reaches_done", {31'd0, done1}, 32'd1);
        chk("restart_err_final", {23'd0, err1}, 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
